// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle data-memory port to a req/ack bus.
// Stores are posted into a small FIFO; loads wait for it to drain first.
module data_mem_bridge #(
  parameter int          WB_DEPTH       = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_rd,
  input  logic                      mem_wr,
  input  logic [31:0]               ram_addr,
  input  logic [31:0]               data_mem_in,
  output logic [31:0]               data_mem_out,
  output logic                      stall,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  input  logic [31:0]               bus_rdata,
  input  logic                      bus_ack,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      bus_err
);

  localparam int            AW   = $clog2(WB_DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(WB_DEPTH);
  localparam logic [15:0]   TLIM = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS_WR, BUS_RD, RD_DONE} state_t;

  state_t        state, next_state;
  logic [31:0]   wb_addr [WB_DEPTH];
  logic [31:0]   wb_data [WB_DEPTH];
  logic [AW-1:0] head, tail, next_head;
  logic [AW:0]   count_after;
  logic [15:0]   tcnt;
  logic          rd_req, push, pop, done, timeout_hit;
  logic          req_d, we_d;
  logic [31:0]   addr_d, wdata_d;

  assign rd_req      = mem_rd && !mem_wr;
  assign push        = mem_wr && (wb_count != FULL);
  assign timeout_hit = bus_req && !bus_ack && (tcnt == TLIM);
  assign done        = bus_req && (bus_ack || timeout_hit);
  assign pop         = (state == BUS_WR) && done;
  assign count_after = wb_count - (AW+1)'(pop);
  assign next_head   = pop ? head + AW'(1) : head;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wb_count != '0) next_state = BUS_WR;
        else if (rd_req)    next_state = BUS_RD;
      end
      BUS_WR: begin
        if (done) begin
          if (count_after != '0) next_state = BUS_WR;
          else if (rd_req)       next_state = BUS_RD;
          else                   next_state = IDLE;
        end
      end
      BUS_RD:  if (done) next_state = RD_DONE;
      RD_DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered bus outputs; a read latches the address once on entry.
  always_comb begin
    req_d   = (next_state == BUS_WR) || (next_state == BUS_RD);
    we_d    = (next_state == BUS_WR);
    addr_d  = bus_addr;
    wdata_d = bus_wdata;
    if (next_state == BUS_WR) begin
      addr_d  = wb_addr[next_head];
      wdata_d = wb_data[next_head];
    end else if (next_state == BUS_RD && state != BUS_RD) begin
      addr_d  = ram_addr;
    end
    stall = (mem_wr && wb_count == FULL) || (rd_req && state != RD_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= ram_addr;
      wb_data[tail] <= data_mem_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      wb_count     <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      data_mem_out <= '0;
      bus_err      <= 1'b0;
      tcnt         <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      head      <= next_head;
      wb_count  <= wb_count + (AW+1)'(push) - (AW+1)'(pop);
      bus_req   <= req_d;
      bus_we    <= we_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      if (done)         tcnt <= '0;
      else if (bus_req) tcnt <= tcnt + 16'd1;
      // A timed-out read still completes towards the core, with poisoned data.
      if (state == BUS_RD && done)
        data_mem_out <= bus_ack ? bus_rdata : ERR_DATA;
      if (timeout_hit) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: posted stores, ordered loads, timeout and reset.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_wr;
  logic [31:0] ram_addr, data_mem_in;
  logic [31:0] data_mem_out;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [2:0]  wb_count;
  logic        bus_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int rd_acks      = 0;
  int req_seen;

  data_mem_bridge #(
    .WB_DEPTH(4),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ram_addr(ram_addr), .data_mem_in(data_mem_in), .data_mem_out(data_mem_out),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_count(wb_count), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus_req && !bus_we && bus_ack) rd_acks++;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    mem_rd      = rd;
    mem_wr      = wr;
    ram_addr    = addr;
    data_mem_in = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    checkOutput("rst_data", data_mem_out, 32'h0);
    checkOutput("rst_req", {31'b0, bus_req}, 32'h0);
    checkOutput("rst_count", {29'b0, wb_count}, 32'h0);
    checkOutput("rst_err", {31'b0, bus_err}, 32'h0);
    checkOutput("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;
    next_cycle();

    // Single store
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h12345678);
    checkOutput("t1_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t1_count1", {29'b0, wb_count}, 32'h1);
    checkOutput("t1_req_idle", {31'b0, bus_req}, 32'h0);
    next_cycle();
    checkOutput("t1_req", {31'b0, bus_req}, 32'h1);
    checkOutput("t1_we", {31'b0, bus_we}, 32'h1);
    checkOutput("t1_addr", bus_addr, 32'h100);
    checkOutput("t1_wdata", bus_wdata, 32'h12345678);
    bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    checkOutput("t1_count0", {29'b0, wb_count}, 32'h0);
    checkOutput("t1_req_done", {31'b0, bus_req}, 32'h0);

    // Fill the buffer with ack held low
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h400 + 32'(4*i), 32'hA0 + 32'(i));
      checkOutput("t2_stall", {31'b0, stall}, (i == 4) ? 32'h1 : 32'h0);
      if (i < 4) next_cycle();
    end
    checkOutput("t2_full", {29'b0, wb_count}, 32'h4);
    next_cycle();
    checkOutput("t2_still_full", {29'b0, wb_count}, 32'h4);
    checkOutput("t2_still_stall", {31'b0, stall}, 32'h1);
    checkOutput("t2_head_addr", bus_addr, 32'h400);
    bus_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      if (k == 1) begin
        checkOutput("t2_accept_stall", {31'b0, stall}, 32'h0);
      end
      if (k == 2) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t2_drain_addr", bus_addr, 32'h400 + 32'(4*k));
      checkOutput("t2_drain_data", bus_wdata, 32'hA0 + 32'(k));
      checkOutput("t2_drain_count", {29'b0, wb_count}, (k <= 2) ? 32'h3 : 32'(5 - k));
    end
    next_cycle();
    bus_ack = 1'b0;
    checkOutput("t2_empty", {29'b0, wb_count}, 32'h0);
    checkOutput("t2_idle", {31'b0, bus_req}, 32'h0);

    // Store then load: load waits for the write
    applyStimulus(1'b0, 1'b1, 32'h200, 32'hAAAA0000);
    next_cycle();
    applyStimulus(1'b1, 1'b0, 32'h204, 32'h0);
    checkOutput("t3_ld_stall0", {31'b0, stall}, 32'h1);
    checkOutput("t3_count", {29'b0, wb_count}, 32'h1);
    next_cycle();
    checkOutput("t3_wr_addr", bus_addr, 32'h200);
    checkOutput("t3_wr_we", {31'b0, bus_we}, 32'h1);
    checkOutput("t3_ld_stall1", {31'b0, stall}, 32'h1);
    bus_ack = 1'b1;
    bus_rdata = 32'h55;
    next_cycle();
    checkOutput("t3_rd_req", {31'b0, bus_req}, 32'h1);
    checkOutput("t3_rd_we", {31'b0, bus_we}, 32'h0);
    checkOutput("t3_rd_addr", bus_addr, 32'h204);
    checkOutput("t3_ld_stall2", {31'b0, stall}, 32'h1);
    next_cycle();
    checkOutput("t3_done_stall", {31'b0, stall}, 32'h0);
    checkOutput("t3_done_data", data_mem_out, 32'h55);
    checkOutput("t3_done_req", {31'b0, bus_req}, 32'h0);
    bus_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    checkOutput("t3_one_read", rd_acks, 32'd1);

    // Simultaneous rd and wr: write only
    applyStimulus(1'b1, 1'b1, 32'h300, 32'h33);
    checkOutput("t4_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t4_count", {29'b0, wb_count}, 32'h1);
    next_cycle();
    checkOutput("t4_we", {31'b0, bus_we}, 32'h1);
    checkOutput("t4_addr", bus_addr, 32'h300);
    bus_ack = 1'b1;
    next_cycle();
    bus_ack = 1'b0;
    next_cycle();
    checkOutput("t4_no_read", rd_acks, 32'd1);
    checkOutput("t4_idle", {31'b0, bus_req}, 32'h0);

    // Read timeout
    applyStimulus(1'b1, 1'b0, 32'h500, 32'h0);
    checkOutput("t5_stall0", {31'b0, stall}, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      next_cycle();
      checkOutput("t5_req_held", {31'b0, bus_req}, 32'h1);
      checkOutput("t5_err_low", {31'b0, bus_err}, 32'h0);
      checkOutput("t5_stall_held", {31'b0, stall}, 32'h1);
    end
    next_cycle();
    checkOutput("t5_req_drop", {31'b0, bus_req}, 32'h0);
    checkOutput("t5_err", {31'b0, bus_err}, 32'h1);
    checkOutput("t5_data", data_mem_out, 32'hDEADBEEF);
    checkOutput("t5_stall_drop", {31'b0, stall}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    checkOutput("t5_err_sticky", {31'b0, bus_err}, 32'h1);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h600 + 32'(4*i), 32'hC0 + 32'(i));
      next_cycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("t6_pre_req", {31'b0, bus_req}, 32'h1);
    checkOutput("t6_pre_count", {29'b0, wb_count}, 32'h3);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checkOutput("t6_req", {31'b0, bus_req}, 32'h0);
    checkOutput("t6_count", {29'b0, wb_count}, 32'h0);
    checkOutput("t6_err", {31'b0, bus_err}, 32'h0);
    checkOutput("t6_data", data_mem_out, 32'h0);
    checkOutput("t6_addr", bus_addr, 32'h0);
    checkOutput("t6_wdata", bus_wdata, 32'h0);
    checkOutput("t6_we", {31'b0, bus_we}, 32'h0);
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      if (bus_req) req_seen++;
    end
    checkOutput("t6_no_replay", req_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
